// File: rtl/fft_frame_ctrl.sv
// Run-time sequencer for a streaming FFT core: one config beat, then NFRAMES x NFFT
// source beats gated into the core with tlast, then wait for every output frame to drain.
`timescale 1ns/1ps
module fft_frame_ctrl #(
  parameter int NFFT   = 512,
  parameter int CNT_W  = 9,
  parameter int DATA_W = 64,
  parameter int CFG_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CFG_W-1:0]  cfg_word,
  input  logic [7:0]        nframes,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [DATA_W-1:0] s_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tlast,
  output logic              cfg_tvalid,
  input  logic              cfg_tready,
  output logic [CFG_W-1:0]  cfg_tdata,
  input  logic              o_tvalid,
  input  logic              o_tready,
  input  logic              o_tlast,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {S_IDLE, S_CFG, S_STREAM, S_DRAIN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NFFT - 1);

  state_t           state;
  logic [CNT_W-1:0] in_cnt, out_cnt;
  logic [7:0]       in_frm, out_frm, nfr;
  logic             stream, mon, in_hs, out_hs, in_last, out_last;

  // Data path is a zero-latency pass-through; ready never looks at s_tvalid.
  assign stream   = (state == S_STREAM);
  assign s_tready = stream & m_tready;
  assign m_tvalid = stream & s_tvalid;
  assign m_tdata  = s_tdata;
  assign in_last  = (in_cnt == LAST_BEAT);
  assign m_tlast  = stream & in_last;
  assign in_hs    = m_tvalid & m_tready;

  assign mon      = stream | (state == S_DRAIN);
  assign out_hs   = mon & o_tvalid & o_tready;
  assign out_last = (out_cnt == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      in_cnt     <= '0;
      out_cnt    <= '0;
      in_frm     <= '0;
      out_frm    <= '0;
      nfr        <= '0;
      cfg_tvalid <= 1'b0;
      cfg_tdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      // Output frames close by beat count only; a stray o_tlast just flags err.
      if (out_hs) begin
        out_cnt <= out_cnt + CNT_W'(1);
        if (out_last) out_frm <= out_frm + 8'd1;
        if (o_tlast != out_last) err <= 1'b1;
      end

      unique case (state)
        S_IDLE: begin
          if (start) begin
            cfg_tdata  <= cfg_word;
            nfr        <= (nframes == 8'd0) ? 8'd1 : nframes;
            in_cnt     <= '0;
            out_cnt    <= '0;
            in_frm     <= '0;
            out_frm    <= '0;
            err        <= 1'b0;
            cfg_tvalid <= 1'b1;
            busy       <= 1'b1;
            state      <= S_CFG;
          end
        end
        S_CFG: begin
          if (cfg_tready) begin
            cfg_tvalid <= 1'b0;
            state      <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (in_hs) begin
            in_cnt <= in_cnt + CNT_W'(1);
            if (in_last) begin
              in_frm <= in_frm + 8'd1;
              if (in_frm + 8'd1 == nfr) state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // >= rather than == so surplus output beats cannot strand the run
          if (out_frm >= nfr) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Scoreboard bench for fft_frame_ctrl: driver queues expected FFT-input beats, a negedge
// monitor pops and compares them and checks ready/valid gating every cycle.
`timescale 1ns/1ps
module tb_fft_frame_ctrl;
  localparam int NFFT = 512, CNT_W = 9, DATA_W = 64, CFG_W = 16;

  logic              clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [CFG_W-1:0]  cfg_word = '0;
  logic [7:0]        nframes = '0;
  logic              s_tvalid = 1'b0, s_tready;
  logic [DATA_W-1:0] s_tdata = '0;
  logic              m_tvalid, m_tready = 1'b0, m_tlast;
  logic [DATA_W-1:0] m_tdata;
  logic              cfg_tvalid, cfg_tready = 1'b0;
  logic [CFG_W-1:0]  cfg_tdata;
  logic              o_tvalid = 1'b0, o_tready = 1'b0, o_tlast = 1'b0;
  logic              busy, done, err;

  always #5 clk = ~clk;

  fft_frame_ctrl #(.NFFT(NFFT), .CNT_W(CNT_W), .DATA_W(DATA_W), .CFG_W(CFG_W)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_word(cfg_word), .nframes(nframes),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready), .cfg_tdata(cfg_tdata),
    .o_tvalid(o_tvalid), .o_tready(o_tready), .o_tlast(o_tlast),
    .busy(busy), .done(done), .err(err));

  int nvec = 0, nerr = 0, salt = 0, exp_total = 0, in_seen = 0;
  bit exp_stream = 1'b0;
  logic [DATA_W:0] expq[$];
  logic [DATA_W:0] e;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk(input int i);
    logic [31:0] a, b;
    a = 32'(i) ^ 32'hA5A5_0000 ^ 32'(salt << 20);
    b = 32'(i * 3 + salt);
    return {a, b};
  endfunction

  // Monitor: ready/valid gating every cycle, payload and tlast on every FFT-input beat
  always @(negedge clk) begin
    if (reset) begin
      exp_stream = 1'b0;
      in_seen    = 0;
    end else begin
      chk("s_tready", 64'(s_tready), 64'(exp_stream & m_tready));
      chk("m_tvalid", 64'(m_tvalid), 64'(exp_stream & s_tvalid));
      if (m_tvalid && m_tready) begin
        if (expq.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL beat_unexpected: got %0h want none @%0t", m_tdata, $time);
        end else begin
          e = expq.pop_front();
          chk("m_tdata", m_tdata, e[DATA_W-1:0]);
          chk("m_tlast", 64'(m_tlast), 64'(e[DATA_W]));
        end
        in_seen++;
        if (in_seen == exp_total) exp_stream = 1'b0;
      end
      if (cfg_tvalid && cfg_tready) begin
        exp_stream = 1'b1;
        in_seen    = 0;
      end
    end
  end

  task automatic do_start(input logic [CFG_W-1:0] cfg, input logic [7:0] nf, input int cfg_wait);
    exp_total  = ((nf == 8'd0) ? 1 : int'(nf)) * NFFT;
    salt++;
    cfg_tready = (cfg_wait == 0);
    @(posedge clk); #1;
    cfg_word = cfg; nframes = nf; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cfg_word = ~cfg; nframes = 8'd7;
    @(negedge clk);
    chk("cfg_tvalid_up", 64'(cfg_tvalid), 64'd1);
    chk("cfg_tdata", 64'(cfg_tdata), 64'(cfg));
    chk("busy_cfg", 64'(busy), 64'd1);
    chk("err_cleared", 64'(err), 64'd0);
    if (cfg_wait > 0) begin
      s_tvalid = 1'b1; m_tready = 1'b1;
      repeat (cfg_wait) begin
        @(negedge clk);
        chk("cfg_tvalid_hold", 64'(cfg_tvalid), 64'd1);
        chk("cfg_tdata_hold", 64'(cfg_tdata), 64'(cfg));
      end
      @(posedge clk); #1;
      s_tvalid = 1'b0; cfg_tready = 1'b1;
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("cfg_tvalid_down", 64'(cfg_tvalid), 64'd0);
  endtask

  task automatic feed(input int n, input bit rnd, input int stop_at);
    int idx = 0, cyc = 0;
    bit pushed = 1'b0;
    while (idx < n && idx != stop_at) begin
      @(posedge clk); #1;
      s_tvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_tdata  = mk(idx);
      if (!pushed) begin
        expq.push_back({1'((idx % NFFT) == NFFT - 1), mk(idx)});
        pushed = 1'b1;
      end
      @(negedge clk);
      if (s_tvalid && s_tready) begin idx++; pushed = 1'b0; end
      if (++cyc > n * 20 + 200) begin
        nvec++; nerr++;
        $display("FAIL feed_timeout: got %0d beats want %0d", idx, n);
        break;
      end
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic drain_out(input int n, input bit rnd, input int bad);
    int j = 0, cyc = 0;
    while (j < n) begin
      @(posedge clk); #1;
      o_tvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      o_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      o_tlast  = ((j % NFFT) == NFFT - 1) || (j == bad);
      @(negedge clk);
      if (o_tvalid && o_tready) begin
        chk("done_early", 64'(done), 64'd0);
        chk("err_run", 64'(err), 64'(bad >= 0 && bad < j));
        j++;
      end
      if (++cyc > n * 20 + 200) begin
        nvec++; nerr++;
        $display("FAIL drain_timeout: got %0d beats want %0d", j, n);
        break;
      end
    end
    @(posedge clk); #1;
    o_tvalid = 1'b0; o_tready = 1'b0; o_tlast = 1'b0;
  endtask

  task automatic finish_run(input bit rnd, input int bad);
    feed(exp_total, rnd, -1);
    @(negedge clk);
    chk("busy_drain", 64'(busy), 64'd1);
    drain_out(exp_total, rnd, bad);
    @(negedge clk);
    chk("done_pre", 64'(done), 64'd0);
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd1);
    chk("busy_done", 64'(busy), 64'd0);
    @(negedge clk);
    chk("done_drop", 64'(done), 64'd0);
    chk("err_end", 64'(err), 64'(bad >= 0));
    chk("queue_empty", 64'(expq.size()), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // T1: reset with inputs active, then a plain single-frame run
    s_tvalid = 1'b1; m_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tlast", 64'(m_tlast), 64'd0);
    chk("rst_cfg_tvalid", 64'(cfg_tvalid), 64'd0);
    chk("rst_cfg_tdata", 64'(cfg_tdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0; s_tvalid = 1'b0;

    do_start(16'h0155, 8'd1, 0);
    finish_run(1'b0, -1);

    // T2: config channel stalled for 5 cycles
    do_start(16'h3C21, 8'd1, 5);
    finish_run(1'b0, -1);

    // T3: random source valid / sink ready on both sides
    do_start(16'h0002, 8'd1, 0);
    finish_run(1'b1, -1);

    // T4: three frames, then nframes=0 acting as one
    do_start(16'h1111, 8'd3, 0);
    finish_run(1'b0, -1);
    do_start(16'h2222, 8'd0, 0);
    finish_run(1'b0, -1);

    // T5: misplaced o_tlast on output beat 510
    do_start(16'h0155, 8'd1, 0);
    finish_run(1'b0, 510);
    repeat (2) @(negedge clk);
    chk("err_sticky", 64'(err), 64'd1);

    // T6: ignored start while busy, abort by reset at beat 200, then a clean run
    do_start(16'h0A0A, 8'd2, 0);
    @(posedge clk); #1;
    start = 1'b1; cfg_word = 16'hBEEF;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("ign_cfg_tvalid", 64'(cfg_tvalid), 64'd0);
    chk("ign_cfg_tdata", 64'(cfg_tdata), 64'h0A0A);
    chk("ign_busy", 64'(busy), 64'd1);
    feed(2 * NFFT, 1'b0, 200);
    @(posedge clk); #1;
    reset = 1'b1; s_tvalid = 1'b1; m_tready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_s_tready", 64'(s_tready), 64'd0);
    chk("abort_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("abort_m_tlast", 64'(m_tlast), 64'd0);
    chk("abort_cfg_tvalid", 64'(cfg_tvalid), 64'd0);
    chk("abort_cfg_tdata", 64'(cfg_tdata), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_queue", 64'(expq.size()), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0; s_tvalid = 1'b0;
    expq.delete();
    do_start(16'h0155, 8'd1, 0);
    finish_run(1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
